// File: rtl/fetch_queue_if.sv
// Bundle between fetch/control (master) and the fetch queue (slave).
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            push_valid;
  logic            push2_valid;
  logic [XLEN-1:0] push_instr1;
  logic [XLEN-1:0] push_instr2;
  logic [XLEN-1:0] push_pc;
  logic            fifo_stall;
  logic            fifo_rst;
  logic            fifo_full;
  logic            out1_valid;
  logic            out2_valid;
  logic [XLEN-1:0] out1_instr;
  logic [XLEN-1:0] out2_instr;
  logic [XLEN-1:0] out1_pc;
  logic [XLEN-1:0] out2_pc;
  logic [CW-1:0]   count;

  modport master (
    output push_valid, push2_valid, push_instr1, push_instr2, push_pc,
           fifo_stall, fifo_rst,
    input  fifo_full, out1_valid, out2_valid, out1_instr, out2_instr,
           out1_pc, out2_pc, count
  );

  modport slave (
    input  push_valid, push2_valid, push_instr1, push_instr2, push_pc,
           fifo_stall, fifo_rst,
    output fifo_full, out1_valid, out2_valid, out1_instr, out2_instr,
           out1_pc, out2_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: up to two pushes and two pops per cycle,
// circular buffer of {instr, pc}, validity tracked only by the occupancy count.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [1:0]    push_n, pop_n;
  logic          full;

  assign rd_ptr_p1 = rd_ptr_q + AW'(1);
  assign wr_ptr_p1 = wr_ptr_q + AW'(1);
  assign full      = (CW'(DEPTH) - count_q) < CW'(2);

  always_comb begin
    push_n = 2'd0;
    if (fq.push_valid && !full && !fq.fifo_rst)
      push_n = fq.push2_valid ? 2'd2 : 2'd1;
  end

  // Decode takes everything it is shown unless stalled.
  always_comb begin
    pop_n = 2'd0;
    if (!fq.fifo_stall && !fq.fifo_rst)
      pop_n = (count_q >= CW'(2)) ? 2'd2 : {1'b0, count_q[0]};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop_n);
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    count_d  = count_q + CW'(push_n) - CW'(pop_n);
    if (fq.fifo_rst) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      instr_mem_q[wr_ptr_q] <= fq.push_instr1;
      pc_mem_q[wr_ptr_q]    <= fq.push_pc;
    end
    if (push_n == 2'd2) begin
      instr_mem_q[wr_ptr_p1] <= fq.push_instr2;
      pc_mem_q[wr_ptr_p1]    <= fq.push_pc + XLEN'(4);
    end
  end

  assign fq.fifo_full  = full;
  assign fq.count      = count_q;
  assign fq.out1_valid = count_q >= CW'(1);
  assign fq.out2_valid = count_q >= CW'(2);
  assign fq.out1_instr = instr_mem_q[rd_ptr_q];
  assign fq.out1_pc    = pc_mem_q[rd_ptr_q];
  assign fq.out2_instr = instr_mem_q[rd_ptr_p1];
  assign fq.out2_pc    = pc_mem_q[rd_ptr_p1];
endmodule
